// File: rtl/bg_layer_priority_select.sv
// Picks the front-most opaque enabled BG layer (and the one behind it) from a serial bgno 0..3 word stream.
// Latency: pixel record registered 1 clock after the bgno 3 word; bg_valid low freezes all pixel state.
// Optional second-layer tracking under `define BG_SECOND_LAYER_EN; without it sec_* are backdrop constants.
module bg_layer_priority_select #(
    parameter int COL_W = 9
) (
    input  logic             clock,
    input  logic             rst_b,
    input  logic [19:0]      bg_data,
    input  logic             bg_valid,
    input  logic             line_start,
    input  logic [15:0]      dispcnt,
    output logic             pix_valid,
    output logic [COL_W-1:0] pix_col,
    output logic [14:0]      top_data,
    output logic [1:0]       top_bgno,
    output logic [1:0]       top_prio,
    output logic             top_bd,
    output logic [14:0]      sec_data,
    output logic [1:0]       sec_bgno,
    output logic [1:0]       sec_prio,
    output logic             sec_bd,
    output logic             seq_err
);

    typedef struct packed {
        logic [14:0] data;
        logic [1:0]  bgno;
        logic [1:0]  prio;
        logic        bd;
    } layer_t;

    typedef enum logic [1:0] {S_WAIT, S_GOT0, S_GOT1, S_GOT2} state_t;

    localparam layer_t BACKDROP = {15'd0, 2'd0, 2'd3, 1'b1};

    state_t           state, state_nxt;
    logic             take, emit, seq_err_nxt;
    logic [1:0]       w_bgno;
    logic [3:0]       bg_en;
    logic             w_cand, beats_best;
    layer_t           new_l, cur_best, ins_best, best_q, top_q;
    logic [COL_W-1:0] cnt;

    wire unused_ok = &{1'b0, dispcnt[15:12], dispcnt[7:0]};

    assign w_bgno = bg_data[16:15];
    assign bg_en  = dispcnt[11:8];
    assign w_cand = bg_valid && !bg_data[19] && bg_en[w_bgno];
    assign new_l  = {bg_data[14:0], w_bgno, bg_data[18:17], 1'b0};

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) state <= S_WAIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        emit        = 1'b0;
        seq_err_nxt = 1'b0;
        if (bg_valid) begin
            if (w_bgno == 2'd0) begin
                // bgno 0 always restarts a pixel; only a surprise if one was in flight
                state_nxt   = S_GOT0;
                take        = 1'b1;
                seq_err_nxt = (state != S_WAIT);
            end else if (state == S_GOT0 && w_bgno == 2'd1) begin
                state_nxt = S_GOT1;
                take      = 1'b1;
            end else if (state == S_GOT1 && w_bgno == 2'd2) begin
                state_nxt = S_GOT2;
                take      = 1'b1;
            end else if (state == S_GOT2 && w_bgno == 2'd3) begin
                state_nxt = S_WAIT;
                emit      = 1'b1;
            end else begin
                state_nxt   = S_WAIT;
                seq_err_nxt = 1'b1;
            end
        end
    end

    // Running state is cleared before the bgno 0 word is inserted
    assign cur_best   = (w_bgno == 2'd0) ? BACKDROP : best_q;
    assign beats_best = w_cand && (cur_best.bd || (new_l.prio < cur_best.prio));
    assign ins_best   = beats_best ? new_l : cur_best;

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            best_q    <= BACKDROP;
            top_q     <= BACKDROP;
            pix_valid <= 1'b0;
            pix_col   <= '0;
            cnt       <= '0;
            seq_err   <= 1'b0;
        end else begin
            pix_valid <= emit;
            seq_err   <= seq_err_nxt;
            if (take) best_q <= ins_best;
            if (emit) begin
                top_q   <= ins_best;
                pix_col <= cnt;
            end
            // line_start wins over the post-emit increment
            if (line_start) cnt <= '0;
            else if (emit)  cnt <= cnt + {{(COL_W-1){1'b0}}, 1'b1};
        end
    end

    assign top_data = top_q.data;
    assign top_bgno = top_q.bgno;
    assign top_prio = top_q.prio;
    assign top_bd   = top_q.bd;

`ifdef BG_SECOND_LAYER_EN
    layer_t cur_sec, ins_sec, sec_q, sec_out_q;
    logic   beats_sec;

    assign cur_sec   = (w_bgno == 2'd0) ? BACKDROP : sec_q;
    assign beats_sec = w_cand && (cur_sec.bd || (new_l.prio < cur_sec.prio));

    always_comb begin
        ins_sec = cur_sec;
        if (beats_best)     ins_sec = cur_best;
        else if (beats_sec) ins_sec = new_l;
    end

    always_ff @(posedge clock or negedge rst_b) begin
        if (!rst_b) begin
            sec_q     <= BACKDROP;
            sec_out_q <= BACKDROP;
        end else begin
            if (take) sec_q     <= ins_sec;
            if (emit) sec_out_q <= ins_sec;
        end
    end

    assign sec_data = sec_out_q.data;
    assign sec_bgno = sec_out_q.bgno;
    assign sec_prio = sec_out_q.prio;
    assign sec_bd   = sec_out_q.bd;
`else
    assign sec_data = 15'd0;
    assign sec_bgno = 2'd0;
    assign sec_prio = 2'd3;
    assign sec_bd   = 1'b1;
`endif

endmodule
